// File: rtl/native_bus_pkg.sv
// Shared types and constants for the native bus decoder slice.
package native_bus_pkg;

  // Widest native address the request record can carry; ADDR_WIDTH must not exceed it.
  localparam int NATIVE_ADDR_W = 16;

  // Word returned to the bridge when a slave never answers.
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_DRAIN
  } native_dec_state_t;

  typedef struct packed {
    logic [NATIVE_ADDR_W-1:0] address;
    logic [31:0]              data;
    logic [3:0]               strb;
  } native_req_t;

endpackage

// File: rtl/native_bus_timer.sv
// Loadable, saturating 16-bit wait counter with a terminal-count flag.
// Used by native_bus_decoder only when NATIVE_DECODER_TIMEOUT_EN is defined.
module native_bus_timer #(
  parameter logic [15:0] TERMINAL = 16'd255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  logic [15:0] r_count;

  // Clear on load, otherwise count up and hold once the terminal value is reached.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_en && (r_count != TERMINAL)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_tc = (r_count == TERMINAL);

endmodule

// File: rtl/native_bus_decoder.sv
// Native request decoder: routes each request to one of NUM_SLAVES regions,
// issues a one-cycle strobe and returns exactly one response pulse.
// Optional feature: NATIVE_DECODER_TIMEOUT_EN adds the wait-cycle timeout
// (error word plus sticky timeout_o); without it WAIT blocks until the slave answers.
module native_bus_decoder
  import native_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [ADDR_WIDTH-1:0]    address_i,
  input  logic [31:0]              data_i,
  input  logic [3:0]               write_strb_i,
  input  logic                     data_valid_i,
  output logic [31:0]              data_o,
  output logic                     data_valid_o,
  output logic [ADDR_WIDTH-1:0]    s_address_o,
  output logic [31:0]              s_data_o,
  output logic [3:0]               s_write_strb_o,
  output logic [NUM_SLAVES-1:0]    s_valid_o,
  input  logic [NUM_SLAVES*32-1:0] s_data_i,
  input  logic [NUM_SLAVES-1:0]    s_valid_i,
  output logic                     timeout_o
);

  localparam int SEL_BITS = $clog2(NUM_SLAVES);

  if (NUM_SLAVES < 2 || (NUM_SLAVES & (NUM_SLAVES - 1)) != 0) begin : g_bad_slaves
    $error("NUM_SLAVES must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  native_dec_state_t     r_state;
  native_dec_state_t     w_next;
  native_req_t           r_req;
  native_req_t           w_req;
  logic [SEL_BITS-1:0]   r_sel;
  logic [SEL_BITS-1:0]   w_sel;
  logic [NUM_SLAVES-1:0] w_onehot;
  logic [NUM_SLAVES-1:0] r_s_valid;
  logic [31:0]           r_data;
  logic                  r_data_valid;
  logic                  w_hit;
  logic [31:0]           w_slv_data [NUM_SLAVES];

  for (genvar n = 0; n < NUM_SLAVES; n++) begin : g_unpack
    assign w_slv_data[n] = s_data_i[32*n +: 32];
  end

  assign w_sel    = address_i[ADDR_WIDTH-1 -: SEL_BITS];
  assign w_onehot = {{(NUM_SLAVES-1){1'b0}}, 1'b1} << w_sel;
  assign w_hit    = s_valid_i[r_sel];
  assign w_req    = '{address: NATIVE_ADDR_W'(address_i), data: data_i, strb: write_strb_i};

`ifdef NATIVE_DECODER_TIMEOUT_EN
  logic w_tc;
  logic r_timeout;

  native_bus_timer #(
    .TERMINAL(16'(TIMEOUT_CYCLES))
  ) u_timer (
    .i_clk   (clk_i),
    .i_rst_n (reset_n_i),
    .i_load  (r_state == ST_ISSUE),
    .i_en    ((r_state == ST_WAIT) && !w_hit),
    .o_tc    (w_tc)
  );

  // Sticky timeout flag; a response on the terminal cycle takes priority and leaves it clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_timeout <= 1'b0;
    end else if ((r_state == ST_WAIT) && !w_hit && w_tc) begin
      r_timeout <= 1'b1;
    end
  end

  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: one strobe per request, one response, then wait for the request to drop.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (data_valid_i) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT: begin
        if (w_hit) begin
          w_next = ST_RESP;
        end
`ifdef NATIVE_DECODER_TIMEOUT_EN
        else if (w_tc) begin
          w_next = ST_RESP;
        end
`endif
      end
      ST_RESP:  w_next = ST_DRAIN;
      ST_DRAIN: if (!data_valid_i) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Request capture, slave strobe, response capture and the one-cycle response pulse.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_req        <= '0;
      r_sel        <= '0;
      r_s_valid    <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_s_valid    <= '0;
      r_data_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (data_valid_i) begin
            r_req     <= w_req;
            r_sel     <= w_sel;
            r_s_valid <= w_onehot;
          end
        end
        ST_WAIT: begin
          if (w_hit) begin
            r_data       <= w_slv_data[r_sel];
            r_data_valid <= 1'b1;
          end
`ifdef NATIVE_DECODER_TIMEOUT_EN
          else if (w_tc) begin
            r_data       <= ERR_DATA;
            r_data_valid <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign data_o         = r_data;
  assign data_valid_o   = r_data_valid;
  assign s_address_o    = ADDR_WIDTH'(r_req.address);
  assign s_data_o       = r_req.data;
  assign s_write_strb_o = r_req.strb;
  assign s_valid_o      = r_s_valid;

endmodule

// File: tb/tb_native_bus_decoder.sv
// Scoreboard bench for native_bus_decoder: the driver plays bridge and slaves,
// pushes expected strobes/responses; a negedge monitor pops and compares.
module tb_native_bus_decoder;

  localparam int          AW  = 16;
  localparam int          NS  = 4;
  localparam int          TMO = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic            clk = 1'b0;
  logic            reset_n_i;
  logic [AW-1:0]   address_i;
  logic [31:0]     data_i;
  logic [3:0]      write_strb_i;
  logic            data_valid_i;
  logic [31:0]     data_o;
  logic            data_valid_o;
  logic [AW-1:0]   s_address_o;
  logic [31:0]     s_data_o;
  logic [3:0]      s_write_strb_o;
  logic [NS-1:0]   s_valid_o;
  logic [NS*32-1:0] s_data_i;
  logic [NS-1:0]   s_valid_i;
  logic            timeout_o;

  always #5 clk = ~clk;

  native_bus_decoder #(
    .ADDR_WIDTH(AW), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .address_i(address_i), .data_i(data_i),
    .write_strb_i(write_strb_i), .data_valid_i(data_valid_i), .data_o(data_o),
    .data_valid_o(data_valid_o), .s_address_o(s_address_o), .s_data_o(s_data_o),
    .s_write_strb_o(s_write_strb_o), .s_valid_o(s_valid_o), .s_data_i(s_data_i),
    .s_valid_i(s_valid_i), .timeout_o(timeout_o)
  );

  typedef struct { logic [3:0] oh; logic [15:0] addr; logic [31:0] data; logic [3:0] strb; } stb_t;
  typedef struct { logic [31:0] data; logic to; int lat; logic [15:0] addr; } rsp_t;

  stb_t stb_q[$];
  rsp_t rsp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   stb_cyc = 0;
  int   resp_cnt = 0;
  logic model_to = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " data_valid_o"}, data_valid_o, 0);
    check({tag, " s_valid_o"}, s_valid_o, 0);
    check({tag, " timeout_o"}, timeout_o, 0);
    check({tag, " data_o"}, data_o, 0);
    check({tag, " s_address_o"}, s_address_o, 0);
    check({tag, " s_data_o"}, s_data_o, 0);
    check({tag, " s_write_strb_o"}, s_write_strb_o, 0);
  endtask

  // Monitor: compares every strobe and every response against the queued expectations.
  always @(negedge clk) begin : mon
    stb_t se;
    rsp_t re;
    if (reset_n_i === 1'b1) begin
      if (s_valid_o != '0) begin
        if (stb_q.size() == 0) begin
          check("unexpected strobe", s_valid_o, 0);
        end else begin
          se = stb_q.pop_front();
          check("strobe one-hot", s_valid_o, se.oh);
          check("strobe address", s_address_o, se.addr);
          check("strobe wdata", s_data_o, se.data);
          check("strobe wstrb", s_write_strb_o, se.strb);
          stb_cyc = cyc;
        end
      end
      if (data_valid_o) begin
        resp_cnt++;
        if (rsp_q.size() == 0) begin
          check("unexpected response", data_valid_o, 0);
        end else begin
          re = rsp_q.pop_front();
          check("resp data", data_o, re.data);
          check("resp timeout flag", timeout_o, re.to);
          check("resp latency", cyc - stb_cyc, re.lat);
          check("address held to resp", s_address_o, re.addr);
        end
      end
    end
  end

  // One complete bridge transaction plus the selected slave's behaviour.
  // d: slave answers d cycles after its strobe; resp=0: slave never answers.
  task automatic do_req(input logic [15:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                        input int d, input bit resp, input bit spur, input int hold,
                        input logic [31:0] rdata);
    int   sel;
    int   osel;
    int   n;
    int   prev;
    bit   tmo;
    stb_t se;
    rsp_t re;
    begin
      sel  = int'(addr[15:14]);
      osel = (sel + 1 + int'($urandom_range(0, 2))) % NS;
`ifdef NATIVE_DECODER_TIMEOUT_EN
      tmo = !resp || (d > TMO + 1);
`else
      tmo = 1'b0;
`endif
      model_to = model_to | tmo;
      se.oh = 4'b0001 << sel; se.addr = addr; se.data = wdata; se.strb = strb;
      stb_q.push_back(se);
      re.data = tmo ? ERR : rdata; re.to = model_to; re.lat = tmo ? TMO + 2 : d + 1; re.addr = addr;
      rsp_q.push_back(re);
      prev = resp_cnt;

      @(negedge clk);
      address_i = addr; data_i = wdata; write_strb_i = strb; data_valid_i = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (s_valid_o == '0 && n < 10);
      if (s_valid_o == '0) check("strobe wait", s_valid_o, se.oh);

      for (int i = 1; i <= d; i++) begin
        @(negedge clk);
        s_valid_i = '0;
        if (spur && i == 1 && d >= 2) begin
          s_valid_i[osel] = 1'b1;
          s_data_i[32*osel +: 32] = $urandom;
        end
        if (i == d && resp) begin
          s_valid_i[sel] = 1'b1;
          s_data_i[32*sel +: 32] = rdata;
        end
      end
      @(negedge clk);
      s_valid_i = '0;

      n = 0;
      while (resp_cnt == prev && n < TMO + 20) begin
        @(negedge clk);
        n++;
      end
      if (resp_cnt == prev) check("response wait", resp_cnt, prev + 1);
      repeat (hold) @(negedge clk);
      data_valid_i = 1'b0;
      repeat (2 + $urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int  sel;
    int  d;
    bit  resp;
    stb_t se;
    reset_n_i = 1'b0; address_i = '0; data_i = '0; write_strb_i = '0;
    data_valid_i = 1'b0; s_data_i = '0; s_valid_i = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n_i = 1'b1;

    // Read of slave 1, answered two cycles after the strobe.
    do_req(16'h4010, 32'h0, 4'b0000, 2, 1'b1, 1'b0, 0, 32'h1234_5678);
    // Write to slave 3, answered one cycle after the strobe.
    do_req(16'hC004, 32'hA5A5_0001, 4'b0011, 1, 1'b1, 1'b0, 0, 32'h0BAD_F00D);
    // Request held five cycles after its response.
    do_req(16'h0020, 32'h1111_2222, 4'b1111, 3, 1'b1, 1'b0, 5, 32'h5555_AAAA);
    // Spurious slave pulse, then the selected slave answers on the terminal cycle.
    do_req(16'h8008, 32'h0, 4'b0000, TMO + 1, 1'b1, 1'b1, 0, 32'hC0FF_EE01);
`ifdef NATIVE_DECODER_TIMEOUT_EN
    // Slave 2 never answers.
    do_req(16'h8010, 32'h0, 4'b0000, 0, 1'b0, 1'b0, 0, 32'h0);
    // Answer arrives one cycle too late and must be ignored.
    do_req(16'h8014, 32'h0, 4'b0000, TMO + 2, 1'b1, 1'b0, 1, 32'h7777_7777);
    // Flag stays set across a normal transaction.
    do_req(16'h4000, 32'h0, 4'b0000, 1, 1'b1, 1'b0, 0, 32'h2468_ACE0);
`endif

    for (int k = 0; k < 40; k++) begin
      sel = int'($urandom_range(0, NS - 1));
      d   = int'($urandom_range(1, 6));
`ifdef NATIVE_DECODER_TIMEOUT_EN
      resp = ($urandom_range(0, 9) != 0);
`else
      resp = 1'b1;
`endif
      do_req({sel[1:0], 14'($urandom) & 14'h3FFC}, $urandom, 4'($urandom),
             d, resp, 1'($urandom), int'($urandom_range(0, 3)), $urandom);
    end

    // Reset during WAIT; a later slave answer must produce nothing.
    se.oh = 4'b0100; se.addr = 16'h8040; se.data = 32'h0; se.strb = 4'b0000;
    stb_q.push_back(se);
    @(negedge clk);
    address_i = 16'h8040; data_i = '0; write_strb_i = '0; data_valid_i = 1'b1;
    for (int n = 0; n < 10 && s_valid_o == '0; n++) @(negedge clk);
    @(negedge clk);
    reset_n_i = 1'b0;
    data_valid_i = 1'b0;
    model_to = 1'b0;
    #1;
    check_zero("mid reset");
    @(negedge clk);
    reset_n_i = 1'b1;
    @(negedge clk);
    s_valid_i[2] = 1'b1;
    s_data_i[64 +: 32] = 32'h9999_0000;
    @(negedge clk);
    s_valid_i = '0;
    for (int n = 0; n < 6; n++) begin
      check("no response after reset", data_valid_o, 0);
      @(negedge clk);
    end

    do_req(16'h4008, 32'h0, 4'b0000, 2, 1'b1, 1'b0, 0, 32'hFEED_0001);
    repeat (5) @(negedge clk);
    check("pending responses", rsp_q.size(), 0);
    check("pending strobes", stb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/native_bus_decoder.md
# native_bus_decoder

Downstream consumer of the Wishbone-to-native bridge's native request port. It decodes each native request to one of `NUM_SLAVES` peripheral regions, registers the request and issues it to the selected slave as a single-cycle strobe. It waits for that slave's response and returns exactly one response pulse to the bridge, where the pulse becomes the Wishbone ack. An optional timeout answers requests to slaves that never respond.

## Interface
- `ADDR_WIDTH`, 16, native byte-address width
- `NUM_SLAVES`, 4, number of slave regions; power of two, ≥2; `SEL_BITS = $clog2(NUM_SLAVES)`
- `TIMEOUT_CYCLES`, 255, wait-cycle limit before an error response (1..65535)

Ports:
- `clk_i` in 1: the single clock
- `reset_n_i` in 1: reset, asynchronous, active-low
- `address_i` in ADDR_WIDTH: request byte address (low 2 bits zero)
- `data_i` in 32: write data
- `write_strb_i` in 4: byte write strobes; 0 means read
- `data_valid_i` in 1: request; level, held until the response is seen
- `data_o` out 32: read data, valid with `data_valid_o`
- `data_valid_o` out 1: one-cycle response pulse
- `s_address_o` out ADDR_WIDTH: registered address, broadcast to all slaves
- `s_data_o` out 32: registered write data, broadcast
- `s_write_strb_o` out 4: registered strobes, broadcast
- `s_valid_o` out NUM_SLAVES: one-hot, one-cycle request strobe
- `s_data_i` in NUM_SLAVES*32: per-slave read data; slave n occupies bits [32n+31:32n]
- `s_valid_i` in NUM_SLAVES: per-slave response pulse
- `timeout_o` out 1: sticky flag, set on any timeout

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - Enter ISSUE on `data_valid_i`=1.
  - Register `address_i`, `data_i` and `write_strb_i` into the `s_*` registers.
  - Register `sel = address_i[ADDR_WIDTH-1 -: SEL_BITS]`.
- ISSUE: assert `s_valid_o[sel]` for one cycle, clear the wait counter, go to WAIT.
- WAIT:
  - On `s_valid_i[sel]`=1: capture `s_data_i[sel]` into the read-data register, go to RESP.
  - Otherwise increment the counter.
  - When the counter reaches `TIMEOUT_CYCLES`: load `ERR_DATA` (32'hDEAD_BEEF), set `timeout_o`, go to RESP.
- RESP: `data_valid_o`=1 for exactly one cycle; `data_o` shows the captured word. Go to DRAIN.
- DRAIN: return to IDLE once `data_valid_i`=0. The held request is never re-issued.
- The register stage is a 4-beat transaction: ISSUE → WAIT (≥1 cycle) → RESP → DRAIN.
- Writes are acknowledged the same way; slave read data on a write is passed through unchanged.
- `s_valid_i` from an unselected slave, or in any state other than WAIT, is ignored.
- A response on the same cycle as the timeout terminal count wins: real data is returned and `timeout_o` is not set.
- The counter is 16 bits and never wraps. It stops at the terminal count.

## Timing
- Reset (asynchronous, `reset_n_i`=0) forces the following; an in-flight transaction is abandoned and later slave responses are ignored:
  - FSM → IDLE
  - `data_valid_o`=0, `s_valid_o`=0, `timeout_o`=0
  - `data_o`=0, `s_address_o`=0, `s_data_o`=0, `s_write_strb_o`=0
  - counter = 0
- All outputs are registered. There is no combinational path from any input to any output.
- Cycle sequence:
  - cycle 0: request sampled
  - cycle 1: `s_valid_o` high
  - slave responds in cycle k (k≥2)
  - cycle k+1: `data_valid_o` high
- Minimum request-to-response latency: 3 cycles.
- Timeout response: `data_valid_o` high at cycle 2+TIMEOUT_CYCLES+1.
- `s_address_o`, `s_data_o` and `s_write_strb_o` stay stable from ISSUE through RESP.

## Configuration
- `NATIVE_DECODER_TIMEOUT_EN` defined: the counter, timeout path and `timeout_o` logic are compiled in.
- Undefined: WAIT waits indefinitely for the slave, no counter is instantiated, and `timeout_o` is tied to 0.

## Structure
- Package `native_bus_pkg` holds:
  - the state enum `native_dec_state_t`
  - the `ERR_DATA` constant
  - the `native_req_t` struct (address, data, strobes)
- Sub-module `native_bus_timer`: a loadable, saturating 16-bit counter with a terminal-count output. It is instantiated only under `NATIVE_DECODER_TIMEOUT_EN`.

## Test plan
- Read of slave 1:
  - Stimulus: `address_i`=16'h4010; slave 1 returns 32'h1234_5678 two cycles after its strobe.
  - Response: `s_valid_o`=4'b0010, then one `data_valid_o` pulse carrying 32'h1234_5678 at cycle 4.
- Write to slave 3:
  - Stimulus: `address_i`=16'hC004, `data_i`=32'hA5A5_0001, strb 4'b0011; slave acks 1 cycle after its strobe.
  - Response: `s_write_strb_o`=4'b0011, `s_data_o` matches, one ack pulse.
- Timeout, `TIMEOUT_CYCLES`=8, macro defined:
  - Stimulus: request to slave 2, which never responds.
  - Response: `data_o`=32'hDEAD_BEEF at cycle 11; `timeout_o` is 1 and stays 1.
- Spurious and coincident responses:
  - Stimulus: slave 0 pulses while slave 2 is selected, then slave 2 responds on the timeout terminal cycle.
  - Response: the slave-0 pulse is ignored; slave 2's data is returned and `timeout_o` stays 0.
- Held request:
  - Stimulus: `data_valid_i` held for 5 cycles after the response.
  - Response: one `s_valid_o` pulse only; the next request is accepted once `data_valid_i` drops.
- Mid-transaction reset:
  - Stimulus: assert `reset_n_i` low during WAIT, then release it; the slave responds afterwards.
  - Response: all outputs are 0 immediately, and no `data_valid_o` pulse follows.
